// File: rtl/micro_seq_pkg.sv
// Shared definitions for the micro-sequencer controller: opcodes,
// slice source-select encodings and the default loop counter width.
package micro_seq_pkg;

  localparam int CNT_W_DEFAULT = 8;

  localparam logic [3:0] OP_JZ     = 4'h0;
  localparam logic [3:0] OP_CJS    = 4'h1;
  localparam logic [3:0] OP_JMP    = 4'h2;
  localparam logic [3:0] OP_CJP    = 4'h3;
  localparam logic [3:0] OP_PUSHLD = 4'h4;
  localparam logic [3:0] OP_CRTN   = 4'h5;
  localparam logic [3:0] OP_RPCT   = 4'h6;
  localparam logic [3:0] OP_LOOP   = 4'h7;
  localparam logic [3:0] OP_LDAR   = 4'h8;
  localparam logic [3:0] OP_LDCT   = 4'h9;

  typedef enum logic [1:0] {
    SEL_PC  = 2'b00,
    SEL_AR  = 2'b01,
    SEL_STK = 2'b10,
    SEL_DIN = 2'b11
  } sel_e;

endpackage

// File: rtl/micro_seq_if.sv
// Pipeline-register fields in, Am2909 slice controls and status out.
// master = pipeline/slice side, slave = the controller.
interface micro_seq_if #(parameter int CNT_W = micro_seq_pkg::CNT_W_DEFAULT);
  logic [3:0]       instr;
  logic [2:0]       cond_sel;
  logic             cond_pol;
  logic [7:0]       flags_in;
  logic             flags_we;
  logic [CNT_W-1:0] ct_din;
  logic             stall;
  logic             s0;
  logic             s1;
  logic             zero;
  logic             re;
  logic             fe;
  logic             pup;
  logic             cin;
  logic             ct_zero;
  logic [2:0]       depth;
  logic             stack_err;

  modport master (
    output instr, cond_sel, cond_pol, flags_in, flags_we, ct_din, stall,
    input  s0, s1, zero, re, fe, pup, cin, ct_zero, depth, stack_err
  );

  modport slave (
    input  instr, cond_sel, cond_pol, flags_in, flags_we, ct_din, stall,
    output s0, s1, zero, re, fe, pup, cin, ct_zero, depth, stack_err
  );
endinterface

// File: rtl/micro_cond_sel.sv
// Latched status flags and the condition-test mux. The condition always
// sees the flag value from before a same-cycle write.
module micro_cond_sel (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] flags_in,
  input  logic       flags_we,
  input  logic [2:0] cond_sel,
  input  logic       cond_pol,
  output logic       pass
);
  logic [7:0] flag_reg;

  // flag register, written independently of stall
  always_ff @(posedge clock) begin
    if (reset)         flag_reg <= '0;
    else if (flags_we) flag_reg <= flags_in;
  end

  // selected condition with optional inversion
  always_comb begin
    pass = flag_reg[cond_sel] ^ cond_pol;
  end
endmodule

// File: rtl/micro_seq_ctrl.sv
// Next-address control for cascaded Am2909 slices (Am2910-lite role).
// Slice controls are combinational from the microword and registered state.
// Optional macro STACK_GUARD_EN: suppress (fe=1) a push at full or a pop
// at empty instead of letting the slice stack wrap.
module micro_seq_ctrl
  import micro_seq_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int STACK_DEPTH = 4
) (
  input logic        clock,
  input logic        reset,
  micro_seq_if.slave bus
);
  localparam logic [2:0] DEPTH_MAX = 3'(STACK_DEPTH);

  logic [CNT_W-1:0] counter;
  logic [2:0]       depth;
  logic             stack_err;
  logic             pass;
  logic             full;
  logic             empty;
  sel_e             sel;
  logic             push;
  logic             pop;
  logic             cnt_dec;
  logic             cnt_load;
  logic             depth_clr;

  micro_cond_sel u_cond (
    .clock    (clock),
    .reset    (reset),
    .flags_in (bus.flags_in),
    .flags_we (bus.flags_we),
    .cond_sel (bus.cond_sel),
    .cond_pol (bus.cond_pol),
    .pass     (pass)
  );

  assign full  = (depth == DEPTH_MAX);
  assign empty = (depth == 3'd0);

  // opcode decode into slice controls and internal update requests
  always_comb begin
    sel       = SEL_PC;
    bus.zero  = 1'b1;
    bus.re    = 1'b1;
    bus.fe    = 1'b1;
    bus.pup   = 1'b0;
    bus.cin   = 1'b1;
    push      = 1'b0;
    pop       = 1'b0;
    cnt_dec   = 1'b0;
    cnt_load  = 1'b0;
    depth_clr = 1'b0;
    if (reset) begin
      bus.zero = 1'b0;
      bus.cin  = 1'b0;
    end else if (bus.stall) begin
      bus.cin = 1'b0;
    end else begin
      case (bus.instr)
        OP_JZ: begin
          bus.zero  = 1'b0;
          depth_clr = 1'b1;
        end
        OP_CJS:    if (pass) begin sel = SEL_DIN; push = 1'b1; end
        OP_JMP:    sel = SEL_DIN;
        OP_CJP:    if (pass) sel = SEL_DIN;
        OP_PUSHLD: begin push = 1'b1; cnt_load = 1'b1; end
        OP_CRTN:   if (pass) begin sel = SEL_STK; pop = 1'b1; end
        OP_RPCT:   if (counter != '0) begin sel = SEL_AR; cnt_dec = 1'b1; end
        OP_LOOP: begin
          // count remaining: re-read the stack top without popping
          if (counter != '0) begin
            sel     = SEL_STK;
            cnt_dec = 1'b1;
          end else begin
            pop = 1'b1;
          end
        end
        OP_LDAR:   bus.re = 1'b0;
        OP_LDCT:   cnt_load = 1'b1;
        default:   ;
      endcase
      if (push) begin
        bus.fe  = 1'b0;
        bus.pup = 1'b1;
      end
      if (pop) bus.fe = 1'b0;
`ifdef STACK_GUARD_EN
      if ((push && full) || (pop && empty)) bus.fe = 1'b1;
`else
`endif
    end
  end

  // loop counter, depth tracker and sticky stack error
  always_ff @(posedge clock) begin
    if (reset) begin
      counter   <= '0;
      depth     <= 3'd0;
      stack_err <= 1'b0;
    end else begin
      if (cnt_load)                     counter <= bus.ct_din;
      else if (cnt_dec && counter != '0) counter <= counter - 1'b1;
      if (depth_clr) begin
        depth <= 3'd0;
      end else if (push) begin
        if (full) stack_err <= 1'b1;
        else      depth     <= depth + 3'd1;
      end else if (pop) begin
        if (empty) stack_err <= 1'b1;
        else       depth     <= depth - 3'd1;
      end
    end
  end

  assign bus.s1        = sel[1];
  assign bus.s0        = sel[0];
  assign bus.ct_zero   = (counter == '0);
  assign bus.depth     = depth;
  assign bus.stack_err = stack_err;
endmodule

// File: tb/tb_micro_seq_ctrl.sv
// Bench for micro_seq_ctrl: a reference model predicts the slice controls
// for each microword; predictions are queued when the word is driven and
// compared when the outputs are sampled mid-cycle.
module tb_micro_seq_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct {
    logic [1:0] s;
    logic       zero, re, fe, pup, cin, ct_zero;
    logic [2:0] depth;
    logic       err;
  } exp_t;

  exp_t sb_q[$];

  // model state
  logic [7:0] m_cnt, m_flags;
  logic [2:0] m_depth;
  logic       m_err;
  logic       m_push, m_pop, m_dec, m_ld, m_clr;

  // microPC of an idealised slice, driven only by the DUT controls
  logic [7:0] upc;
  logic [7:0] y;

  micro_seq_if #(.CNT_W(8)) bus ();

  micro_seq_ctrl #(.CNT_W(8), .STACK_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  always_comb begin
    if (!bus.zero)                    y = 8'h00;
    else if ({bus.s1, bus.s0} == 2'b00) y = upc;
    else                              y = 8'h40;
  end

  always @(posedge clock) upc <= y + {7'd0, bus.cin};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] op, input logic [2:0] cs,
                      input logic cp, input logic [7:0] fl, input logic fwe,
                      input logic [7:0] ctd, input logic stl);
    exp_t e, g;
    logic pass;
    reset        = rst;
    bus.instr    = op;
    bus.cond_sel = cs;
    bus.cond_pol = cp;
    bus.flags_in = fl;
    bus.flags_we = fwe;
    bus.ct_din   = ctd;
    bus.stall    = stl;

    pass = m_flags[cs] ^ cp;
    e.s = 2'b00; e.zero = 1; e.re = 1; e.fe = 1; e.pup = 0; e.cin = 1;
    m_push = 0; m_pop = 0; m_dec = 0; m_ld = 0; m_clr = 0;
    if (rst) begin
      e.zero = 0; e.cin = 0;
    end else if (stl) begin
      e.cin = 0;
    end else begin
      case (op)
        4'h0: begin e.zero = 0; m_clr = 1; end
        4'h1: if (pass) begin e.s = 2'b11; m_push = 1; end
        4'h2: e.s = 2'b11;
        4'h3: if (pass) e.s = 2'b11;
        4'h4: begin m_push = 1; m_ld = 1; end
        4'h5: if (pass) begin e.s = 2'b10; m_pop = 1; end
        4'h6: if (m_cnt != 0) begin e.s = 2'b01; m_dec = 1; end
        4'h7: if (m_cnt != 0) begin e.s = 2'b10; m_dec = 1; end else m_pop = 1;
        4'h8: e.re = 0;
        4'h9: m_ld = 1;
        default: ;
      endcase
      if (m_push) begin e.fe = 0; e.pup = 1; end
      if (m_pop) e.fe = 0;
`ifdef STACK_GUARD_EN
      if ((m_push && m_depth == 3'd4) || (m_pop && m_depth == 3'd0)) e.fe = 1;
`endif
    end
    e.ct_zero = (m_cnt == 8'd0);
    e.depth   = m_depth;
    e.err     = m_err;
    sb_q.push_back(e);

    @(negedge clock);
    g.s = {bus.s1, bus.s0}; g.zero = bus.zero; g.re = bus.re; g.fe = bus.fe;
    g.pup = bus.pup; g.cin = bus.cin; g.ct_zero = bus.ct_zero;
    g.depth = bus.depth; g.err = bus.stack_err;
    e = sb_q.pop_front();
    check_val("s",         32'(g.s),       32'(e.s));
    check_val("zero",      32'(g.zero),    32'(e.zero));
    check_val("re",        32'(g.re),      32'(e.re));
    check_val("fe",        32'(g.fe),      32'(e.fe));
    check_val("pup",       32'(g.pup),     32'(e.pup));
    check_val("cin",       32'(g.cin),     32'(e.cin));
    check_val("ct_zero",   32'(g.ct_zero), 32'(e.ct_zero));
    check_val("depth",     32'(g.depth),   32'(e.depth));
    check_val("stack_err", 32'(g.err),     32'(e.err));

    @(posedge clock);
    if (rst) begin
      m_cnt = 0; m_flags = 0; m_depth = 0; m_err = 0;
    end else begin
      if (fwe) m_flags = fl;
      if (m_clr) m_depth = 0;
      else if (m_push) begin
        if (m_depth == 3'd4) m_err = 1; else m_depth = m_depth + 3'd1;
      end else if (m_pop) begin
        if (m_depth == 3'd0) m_err = 1; else m_depth = m_depth - 3'd1;
      end
      if (m_ld) m_cnt = ctd;
      else if (m_dec && m_cnt != 0) m_cnt = m_cnt - 8'd1;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_cnt = 0; m_flags = 0; m_depth = 0; m_err = 0;
    upc = 8'hff;
    bus.instr = 4'hA; bus.cond_sel = 0; bus.cond_pol = 0; bus.flags_in = 0;
    bus.flags_we = 0; bus.ct_din = 0; bus.stall = 0;
    @(posedge clock); #1;

    // reset two cycles, then straight-line execution
    step(1, 4'hA, 0, 0, 8'h00, 0, 8'h00, 0);
    step(1, 4'h6, 0, 0, 8'h00, 0, 8'h00, 1);
    check_val("upc_reset", 32'(upc), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'hA, 0, 0, 8'h00, 0, 8'h00, 0);
      check_val("upc_cont", 32'(upc), 32'(i + 1));
    end

    // condition test, including write in the same cycle as evaluation
    step(0, 4'hA, 0, 0, 8'h04, 1, 8'h00, 0);
    step(0, 4'h3, 2, 0, 8'h00, 0, 8'h00, 0);
    step(0, 4'h3, 2, 1, 8'h00, 0, 8'h00, 0);
    step(0, 4'h3, 2, 0, 8'h00, 1, 8'h00, 0);
    step(0, 4'h3, 2, 0, 8'h00, 0, 8'h00, 0);

    // PUSHLD 3 then LOOP: three re-reads, then pop
    step(0, 4'h4, 0, 0, 8'h00, 0, 8'h03, 0);
    check_val("pushld_depth", 32'(bus.depth), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 4'h7, 0, 0, 8'h00, 0, 8'h00, 0);
    check_val("loop_depth", 32'(bus.depth), 32'd0);
    check_val("loop_ct_zero", 32'(bus.ct_zero), 32'd1);

    // five passing calls overflow a 4-deep stack
    for (int i = 0; i < 5; i++) step(0, 4'h1, 1, 1, 8'h00, 0, 8'h00, 0);
    check_val("ovf_depth", 32'(bus.depth), 32'd4);
    check_val("ovf_err", 32'(bus.stack_err), 32'd1);

    // return at empty stack, then reset clears the error
    step(1, 4'hA, 0, 0, 8'h00, 0, 8'h00, 0);
    step(0, 4'h5, 0, 1, 8'h00, 0, 8'h00, 0);
    check_val("unf_err", 32'(bus.stack_err), 32'd1);
    step(1, 4'hA, 0, 0, 8'h00, 0, 8'h00, 0);
    check_val("reset_err", 32'(bus.stack_err), 32'd0);

    // RPCT held by stall, then released
    step(0, 4'h9, 0, 0, 8'h00, 0, 8'h02, 0);
    step(0, 4'h6, 0, 0, 8'h00, 0, 8'h00, 1);
    step(0, 4'h6, 0, 0, 8'h00, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) step(0, 4'h6, 0, 0, 8'h00, 0, 8'h00, 0);
    check_val("rpct_ct_zero", 32'(bus.ct_zero), 32'd1);

    // remaining opcodes and a short random mix
    step(0, 4'h8, 0, 0, 8'h00, 0, 8'h00, 0);
    step(0, 4'h2, 0, 0, 8'h00, 0, 8'h00, 0);
    step(0, 4'h1, 0, 1, 8'h00, 0, 8'h00, 0);
    step(0, 4'h0, 0, 0, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 60; i++)
      step(0, 4'($urandom_range(15)), 3'($urandom_range(7)), 1'($urandom_range(1)),
           8'($urandom), 1'($urandom_range(1)), 8'($urandom_range(3)),
           ($urandom_range(4) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
